// File: rtl/input_gpio_loader.sv
// input_gpio_loader: captures one frame of pixels from a valid/ready pin source
// and writes them to consecutive frame-buffer addresses with one cycle of latency.
module input_gpio_loader #(
    parameter logic [17:0] BASE_ADDR = 18'h00000,
    parameter int          PIXELS    = 160000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic [17:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic [17:0] pixel_count,
    output logic        done,
    output logic        overrun
);
    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
    localparam logic [17:0] LAST = 18'(PIXELS - 1);
    state_t      r_state, w_next;
    logic [17:0] r_addr, r_count;
    logic [7:0]  r_wdata;
    logic        r_we, r_overrun;
    logic        w_accept, w_to_idle;
    assign in_ready    = r_state == LOAD && enable;
    assign w_accept    = in_valid && in_ready;
    assign w_to_idle   = r_state != IDLE && !enable;
    assign done        = r_state == DONE;
    assign mem_addr    = r_addr;
    assign mem_wdata   = r_wdata;
    assign mem_we      = r_we;
    assign pixel_count = r_count;
    assign overrun     = r_overrun;
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        w_next = r_state == IDLE ? (enable ? LOAD : IDLE)
               : !enable ? IDLE
               : (w_accept && r_count == LAST) ? DONE
               : r_state;
    end
    // Dropping back to IDLE (reset or enable removed) clears all frame progress.
    always_ff @(posedge clk) begin
        if (rst || w_to_idle) begin
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_we <= w_accept;
            if (w_accept) begin
                r_addr  <= BASE_ADDR + r_count;
                r_wdata <= in_data;
                r_count <= r_count + 18'd1;
            end
            if (done && in_valid) r_overrun <= 1'b1;
        end
    end
endmodule

// File: tb/tb_input_gpio_loader.sv
// tb_input_gpio_loader: directed checks on small frames plus a randomized
// valid-pattern frame compared against a counting model of the frame.
module tb_input_gpio_loader;
    localparam int          PR = 37;
    localparam logic [17:0] BR = 18'h3FFDB;
    logic clk = 1'b0, rst = 1'b1;
    logic e4 = 0, v4 = 0, e1 = 0, v1 = 0, er = 0, vr = 0;
    logic [7:0] d4 = 0, d1 = 0, dr = 0;
    logic rdy4, we4, dn4, ov4, rdy1, we1, dn1, ov1, rdyr, wer, dnr, ovr;
    logic [17:0] a4, c4, a1, c1, ar, cr;
    logic [7:0] w4, w1, wr;
    int n_cmp = 0, n_err = 0;
    int cnt;
    logic acc;

    always #5 clk = ~clk;

    input_gpio_loader #(.BASE_ADDR(18'h100), .PIXELS(4)) u4 (
        .clk(clk), .rst(rst), .enable(e4), .in_valid(v4), .in_data(d4),
        .in_ready(rdy4), .mem_addr(a4), .mem_wdata(w4), .mem_we(we4),
        .pixel_count(c4), .done(dn4), .overrun(ov4));
    input_gpio_loader #(.BASE_ADDR(18'h3FFFF), .PIXELS(1)) u1 (
        .clk(clk), .rst(rst), .enable(e1), .in_valid(v1), .in_data(d1),
        .in_ready(rdy1), .mem_addr(a1), .mem_wdata(w1), .mem_we(we1),
        .pixel_count(c1), .done(dn1), .overrun(ov1));
    input_gpio_loader #(.BASE_ADDR(BR), .PIXELS(PR)) ur (
        .clk(clk), .rst(rst), .enable(er), .in_valid(vr), .in_data(dr),
        .in_ready(rdyr), .mem_addr(ar), .mem_wdata(wr), .mem_we(wer),
        .pixel_count(cr), .done(dnr), .overrun(ovr));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk4_reset(input string tag);
        chk({tag, "_we"}, 32'(we4), 0);
        chk({tag, "_addr"}, 32'(a4), 0);
        chk({tag, "_wdata"}, 32'(w4), 0);
        chk({tag, "_cnt"}, 32'(c4), 0);
        chk({tag, "_done"}, 32'(dn4), 0);
        chk({tag, "_ovr"}, 32'(ov4), 0);
        chk({tag, "_rdy"}, 32'(rdy4), 0);
    endtask

    initial begin
        tick();
        tick();
        chk4_reset("rst");
        chk("rst_r_we", 32'(wer), 0);
        chk("rst_r_rdy", 32'(rdyr), 0);
        rst = 0;
        // four-pixel frame streamed back to back
        e4 = 1; v4 = 1; d4 = 8'hA0;
        tick();
        chk("f4_rdy", 32'(rdy4), 1);
        for (int i = 0; i < 4; i++) begin
            d4 = 8'(8'hA0 + i);
            tick();
            chk("f4_we", 32'(we4), 1);
            chk("f4_addr", 32'(a4), 32'(18'h100 + i));
            chk("f4_wdata", 32'(w4), 32'(8'hA0 + i));
            chk("f4_cnt", 32'(c4), 32'(i + 1));
        end
        chk("f4_done", 32'(dn4), 1);
        chk("f4_rdy_done", 32'(rdy4), 0);
        tick();
        chk("ovr_we", 32'(we4), 0);
        chk("ovr_set", 32'(ov4), 1);
        chk("ovr_addr_hold", 32'(a4), 32'h103);
        chk("ovr_wdata_hold", 32'(w4), 32'hA3);
        v4 = 0; e4 = 0;
        tick();
        chk4_reset("idle");
        // abort after two beats, then restart
        e4 = 1; v4 = 1; d4 = 8'hB0;
        tick();
        tick();
        chk("ab_addr0", 32'(a4), 32'h100);
        d4 = 8'hB1;
        tick();
        chk("ab_we1", 32'(we4), 1);
        chk("ab_addr1", 32'(a4), 32'h101);
        e4 = 0;
        #1;
        chk("ab_rdy_drop", 32'(rdy4), 0);
        tick();
        chk("ab_we", 32'(we4), 0);
        chk("ab_cnt", 32'(c4), 0);
        e4 = 1; d4 = 8'hC0;
        tick();
        tick();
        chk("re_addr", 32'(a4), 32'h100);
        chk("re_wdata", 32'(w4), 32'hC0);
        chk("re_cnt", 32'(c4), 1);
        // reset in the cycle after the third accepted beat
        d4 = 8'hC1;
        tick();
        d4 = 8'hC2;
        tick();
        chk("rs_addr3", 32'(a4), 32'h102);
        chk("rs_we3", 32'(we4), 1);
        rst = 1; d4 = 8'hC3;
        tick();
        chk4_reset("midrst");
        rst = 0; e4 = 0; v4 = 0;
        // single-pixel frame at the top of the address space
        e1 = 1; v1 = 1; d1 = 8'h5A;
        tick();
        chk("p1_rdy", 32'(rdy1), 1);
        tick();
        chk("p1_we", 32'(we1), 1);
        chk("p1_addr", 32'(a1), 32'h3FFFF);
        chk("p1_wdata", 32'(w1), 32'h5A);
        chk("p1_done", 32'(dn1), 1);
        chk("p1_cnt", 32'(c1), 1);
        chk("p1_rdy_done", 32'(rdy1), 0);
        v1 = 0;
        tick();
        chk("p1_we_after", 32'(we1), 0);
        chk("p1_ovr", 32'(ov1), 0);
        e1 = 0;
        // random valid pattern: pixel k must land at BR+k, in order, exactly once
        er = 1;
        tick();
        cnt = 0;
        for (int cyc = 0; cyc < 2000 && cnt < PR; cyc++) begin
            vr = 1'($urandom_range(0, 1));
            dr = 8'($urandom);
            #1;
            chk("rnd_rdy", 32'(rdyr), 32'(cnt < PR));
            acc = vr && cnt < PR;
            tick();
            chk("rnd_we", 32'(wer), 32'(acc));
            if (acc) begin
                chk("rnd_addr", 32'(ar), 32'(BR + 18'(cnt)));
                chk("rnd_wdata", 32'(wr), 32'(dr));
                cnt++;
            end
            chk("rnd_cnt", 32'(cr), 32'(cnt));
            chk("rnd_done", 32'(dnr), 32'(cnt == PR));
        end
        chk("rnd_complete", 32'(cnt), 32'(PR));
        vr = 1;
        tick();
        chk("rnd_ovr_we", 32'(wer), 0);
        chk("rnd_ovr", 32'(ovr), 1);
        chk("rnd_last_addr", 32'(ar), 32'h3FFFF);
        vr = 0; er = 0;
        tick();
        chk("rnd_idle_done", 32'(dnr), 0);
        chk("rnd_idle_ovr", 32'(ovr), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/input_gpio_loader.md
INPUT_GPIO_LOADER -- requirements
Module: input_gpio_loader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 18'h00000, first frame-buffer address written.
REQ-002 SHALL have parameter PIXELS, default 160000 (400x400), pixels per frame; 1 <= PIXELS and BASE_ADDR+PIXELS-1 <= 18'h3FFFF.
REQ-003 clk  in  1  clock; all state changes on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 enable  in  1  arms/holds a frame capture; deassertion aborts.
REQ-006 in_valid  in  1  external source presents a pixel on in_data.
REQ-007 in_data  in  8  pixel value from input pins.
REQ-008 in_ready  out  1  block accepts a pixel this cycle.
REQ-009 mem_addr  out  18  frame-buffer write address.
REQ-010 mem_wdata  out  8  frame-buffer write data.
REQ-011 mem_we  out  1  frame-buffer write strobe, one cycle per pixel.
REQ-012 pixel_count  out  18  pixels accepted in current frame.
REQ-013 done  out  1  frame fully written.
REQ-014 overrun  out  1  sticky: source offered data after frame complete.

Function
REQ-015 SHALL implement states IDLE, LOAD, DONE.
REQ-016 IDLE: enable=1 -> LOAD next cycle with pixel_count=0; otherwise stay.
REQ-017 in_ready SHALL equal (state==LOAD && enable), combinational from registered state; 0 in IDLE and DONE.
REQ-018 Beat accepted iff in_valid && in_ready at a rising edge; no other condition consumes data.
REQ-019 Accepted beat: next cycle mem_we=1, mem_addr=BASE_ADDR+pixel_count(pre-increment), mem_wdata=in_data; pixel_count increments by 1 (1-cycle write latency).
REQ-020 Cycle with no accepted beat: mem_we=0 next cycle; mem_addr/mem_wdata hold last value in LOAD and DONE.
REQ-021 Back-to-back beats SHALL write consecutive addresses every cycle, no bubbles.
REQ-022 Beat accepted with pixel_count==PIXELS-1 -> DONE next cycle, pixel_count=PIXELS, in_ready=0 that same next cycle; final write issued that cycle.
REQ-023 DONE: done=1, mem_we=0 except final write of REQ-022; in_valid=1 sets overrun=1 (sticky), data discarded, no write.
REQ-024 DONE with enable=0 -> IDLE next cycle.
REQ-025 LOAD with enable=0 -> IDLE next cycle (abort); beat presented that cycle not accepted; a write for a beat accepted the previous cycle still completes.
REQ-026 Entering IDLE: pixel_count=0, done=0, overrun=0, mem_addr=0, mem_wdata=0.
REQ-027 Address arithmetic in 18 bits; addresses never exceed BASE_ADDR+PIXELS-1 and never wrap.
REQ-028 PIXELS=1: single accepted beat -> DONE.

Reset
REQ-029 rst=1 at edge: state=IDLE, mem_we=0, mem_addr=0, mem_wdata=0, pixel_count=0, done=0, overrun=0, in_ready=0; rst has priority over all inputs.
REQ-030 rst mid-LOAD SHALL cancel pending write (mem_we=0 next cycle) and discard frame progress.

Verification
REQ-031 PIXELS=4, BASE_ADDR=0x100, enable=1, in_valid=1 continuous, data 0xA0..0xA3 -> writes 0x100..0x103 in 4 consecutive cycles, done=1 after last, in_ready=0.
REQ-032 Default params, in_valid toggling 1/0, data = low byte of index -> 160000 writes to 0..0x270FF, no skipped/duplicate address, done=1.
REQ-033 PIXELS=4, enable dropped after 2 beats -> 2 writes (0x100,0x101), IDLE, pixel_count=0; re-enable restarts at 0x100.
REQ-034 PIXELS=4 complete, then in_valid=1 in DONE -> overrun=1, no mem_we; enable=0 -> overrun=0, done=0.
REQ-035 rst asserted cycle after 3rd beat accepted -> no 3rd-beat write completes after reset, all outputs at reset values next cycle.
REQ-036 PIXELS=1, BASE_ADDR=0x3FFFF, one beat 0x5A -> single write addr 0x3FFFF data 0x5A, done=1.
